inst_prefetch_unit: RTL and testbench
=====================================

Name: inst_prefetch_unit

Overview:
Parametrised instruction fetch front-end for the multi-cycle and pipelined custom CPUs. It issues sequential fetch requests on the existing instruction request/response channels, with up to MAX_OUTSTANDING requests in flight. Returned instructions are buffered, tagged with their PC, in a DEPTH-entry FIFO consumed by decode. A redirect (branch/jump/exception) flushes the buffer and discards stale responses still in flight.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
MAX_OUTSTANDING, 2, max accepted-but-unanswered requests; 1..DEPTH
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address, word aligned
PC  output  32  fetch request address
Inst_Req_Valid  output  1  fetch request valid
Inst_Req_Ready  input  1  memory accepts request
Instruction  input  32  response data
Inst_Valid  input  1  response valid
Inst_Ready  output  1  unit accepts response
out_valid  output  1  FIFO head valid
out_inst  output  32  FIFO head instruction
out_pc  output  32  FIFO head PC
out_ready  input  1  decode consumes head
occupancy  output  $clog2(DEPTH+1)  current FIFO entry count
perf_req_stall_cnt  output  32  cycles with Inst_Req_Valid=1 and Inst_Req_Ready=0
perf_drop_cnt  output  32  responses discarded as stale

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset takes effect at the clk edge where rst=1.
- Internal state:
  - fetch_pc: next request address.
  - resp_pc: PC of the next live response.
  - inflight: accepted requests not yet answered.
  - stale: how many of inflight are to be discarded; stale <= inflight.
  - FIFO count; head/tail pointers wrap modulo DEPTH.
- Reset values: fetch_pc = resp_pc = RESET_PC; inflight, stale, count, pointers and both perf counters = 0; out_valid=0; Inst_Req_Valid=0; occupancy=0.
- While rst=1: Inst_Ready=1, so stale bus responses are drained. The CPU INIT state does the same.
- PC = fetch_pc (combinational).
- Inst_Req_Valid = !rst && !redirect_valid && (inflight < MAX_OUTSTANDING) && (count + inflight - stale < DEPTH).
  - The credit rule guarantees every live response has a free FIFO slot, so the FIFO never overflows.
- Request fire = Inst_Req_Valid && Inst_Req_Ready. On fire: fetch_pc += 4 (mod 2^32 wrap) and inflight += 1.
  - Once Inst_Req_Valid rises it may only drop on redirect or reset. Credit can only grow while a request is pending, so there is no other reason to drop it.
- Inst_Ready = rst || (inflight != 0).
- Response fire = Inst_Valid && Inst_Ready.
  - If stale > 0: the response is discarded; stale -= 1, inflight -= 1, perf_drop_cnt += 1.
  - Otherwise: push {resp_pc, Instruction}; resp_pc += 4; inflight -= 1.
  - Inst_Valid while inflight = 0 and rst = 0 is a protocol error. It is ignored and Inst_Ready stays 0.
- Request fire and response fire in the same cycle: inflight is unchanged net.
- Output:
  - out_valid = (count != 0); out_inst/out_pc come from the head entry, registered storage.
  - No bypass: a response pushed at edge t is visible at out_valid after edge t.
  - Pop = out_valid && out_ready. Push and pop in the same cycle leave count unchanged, valid at any occupancy.
- Redirect cycle (redirect_valid=1, rst=0):
  - No request is issued in that cycle.
  - At the edge: count=0 and head=tail; fetch_pc = resp_pc = redirect_pc.
  - stale = inflight - (response fire ? 1 : 0); inflight = stale.
  - A response arriving in the redirect cycle is discarded and counts in perf_drop_cnt. A pop in the redirect cycle is void.
- Back-to-back redirects: the last one wins. Stale responses accumulate correctly via the inflight rule.
- Reset mid-operation: all state returns to its reset values regardless of in-flight traffic. The memory side is reset by the same rst.
- perf_req_stall_cnt and perf_drop_cnt wrap at 2^32.

Test Plan:
- Reset, memory always ready with 1-cycle response, out_ready=1 -> requests to PC 0,4,8,...; out_pc sequence 0,4,8 with matching out_inst; first out_valid 1 cycle after the first response.
- out_ready=0, DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 requests issued; occupancy=4; Inst_Req_Valid=0 until a pop, then exactly one new request to PC 0x10.
- Two requests in flight (PC 0x8, 0xC), redirect_pc=0x100 asserted -> both responses discarded, perf_drop_cnt=2; next request to PC 0x100; first out_pc=0x100.
- Redirect in the same cycle as a response and a pop -> FIFO empty next cycle, that response dropped, stale = inflight-1; no entry with the old PC ever appears.
- Inst_Req_Ready held low 5 cycles after reset -> perf_req_stall_cnt=5; PC stays 0 throughout; Inst_Req_Valid stays 1.
- rst asserted with 3 entries buffered and 1 in flight -> next cycle occupancy=0, out_valid=0, PC=RESET_PC, perf counters 0.

Source files
------------

// File: rtl/inst_prefetch_unit_if.sv
// Instruction-fetch bus bundle for inst_prefetch_unit.
//   Request channel  : PC, Inst_Req_Valid (unit -> memory), Inst_Req_Ready (memory -> unit)
//   Response channel : Instruction, Inst_Valid (memory -> unit), Inst_Ready (unit -> memory)
//   Decode channel   : out_valid, out_inst, out_pc (unit -> decode), out_ready (decode -> unit)
// Handshake rule on every channel: a transfer happens on a rising clk edge where
// both valid and ready are 1. A valid, once raised, holds its payload stable
// until the transfer (the request side may drop it only on redirect or reset).
// master = the prefetch unit, slave = memory + decode side.
interface inst_prefetch_unit_if;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    output PC, Inst_Req_Valid, Inst_Ready, out_valid, out_inst, out_pc,
    input  Inst_Req_Ready, Instruction, Inst_Valid, out_ready
  );

  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ready, out_valid, out_inst, out_pc,
    output Inst_Req_Ready, Instruction, Inst_Valid, out_ready
  );
endinterface

// File: rtl/inst_prefetch_unit.sv
// Sequential instruction prefetcher with PC-tagged output FIFO.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   redirect_valid/_pc  : flush the buffer and restart fetch at redirect_pc
//   bus (master)        : fetch request/response channels and decode output
//   occupancy           : FIFO entry count
//   perf_req_stall_cnt  : cycles with a request pending but not accepted
//   perf_drop_cnt       : responses discarded as stale
// Up to MAX_OUTSTANDING requests are in flight. A request is only issued when
// the FIFO is guaranteed a slot for its response, so the FIFO cannot overflow.
// After a redirect the responses still in flight are counted as stale and
// dropped as they return (responses come back in request order).
module inst_prefetch_unit #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  inst_prefetch_unit_if.master         bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                  perf_req_stall_cnt,
  output logic [31:0]                  perf_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q,  resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q,    stale_d;
  logic [CW-1:0] count_q,    count_d;
  logic [AW-1:0] head_q,     head_d;
  logic [AW-1:0] tail_q,     tail_d;
  logic [31:0]   stall_q,    stall_d;
  logic [31:0]   drop_q,     drop_d;
  logic [63:0]   mem_q [DEPTH];   // {pc, instruction}

  logic [CW:0]   committed;       // buffered entries plus live responses still due
  logic          req_valid, req_fire, resp_fire, push, pop;

  assign committed = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, stale_q};

  assign req_valid = !rst && !redirect_valid
                   && (inflight_q < CW'(MAX_OUTSTANDING))
                   && (committed < (CW+1)'(DEPTH));
  assign req_fire  = req_valid && bus.Inst_Req_Ready;
  // Responses with nothing outstanding are protocol errors and are not accepted.
  assign resp_fire = !rst && bus.Inst_Valid && (inflight_q != '0);
  assign push      = resp_fire && !redirect_valid && (stale_q == '0);
  assign pop       = (count_q != '0) && bus.out_ready && !redirect_valid;

  assign bus.PC             = fetch_pc_q;
  assign bus.Inst_Req_Valid = req_valid;
  assign bus.Inst_Ready     = rst || (inflight_q != '0);
  assign bus.out_valid      = (count_q != '0);
  assign bus.out_pc         = mem_q[head_q][63:32];
  assign bus.out_inst       = mem_q[head_q][31:0];
  assign occupancy          = count_q;
  assign perf_req_stall_cnt = stall_q;
  assign perf_drop_cnt      = drop_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    stall_d    = stall_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      // Everything still outstanding becomes stale; a response landing in this
      // very cycle is dropped immediately and so leaves the in-flight set.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      inflight_d = inflight_q - CW'(resp_fire);
      stale_d    = inflight_q - CW'(resp_fire);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      if (resp_fire) drop_d = drop_q + 32'd1;
    end else begin
      inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (req_valid && !bus.Inst_Req_Ready) stall_d = stall_q + 32'd1;
      if (resp_fire && (stale_q != '0)) begin
        stale_d = stale_q - CW'(1);
        drop_d  = drop_q + 32'd1;
      end
      if (push) begin
        tail_d    = tail_q + AW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      stale_q    <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      stall_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      stall_q    <= stall_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= {resp_pc_q, bus.Instruction};
  end
endmodule

// File: tb/tb_inst_prefetch_unit.sv
module tb_inst_prefetch_unit;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [2:0]  occupancy;
  logic [31:0] perf_req_stall_cnt, perf_drop_cnt;

  always #5 clk = ~clk;

  inst_prefetch_unit_if bus();

  inst_prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .rst                (rst),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .bus                (bus),
    .occupancy          (occupancy),
    .perf_req_stall_cnt (perf_req_stall_cnt),
    .perf_drop_cnt      (perf_drop_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environment ----------------
  bit          resp_en  = 1'b1;
  bit          spurious = 1'b0;
  logic [31:0] mem_q[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_0013;
  endfunction

  task automatic drive_mem();
    if (resp_en && mem_q.size() != 0) begin
      bus.Inst_Valid  = 1'b1;
      bus.Instruction = inst_of(mem_q[0]);
    end else if (spurious && mem_q.size() == 0) begin
      bus.Inst_Valid  = 1'b1;
      bus.Instruction = 32'hDEAD_BEEF;
    end else begin
      bus.Inst_Valid  = 1'b0;
      bus.Instruction = 32'h0;
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [31:0] addr; logic stale; } ot_t;
  logic [31:0] m_fetch_pc;
  ot_t         m_ot[$];       // outstanding requests, oldest first
  logic [63:0] m_fifo[$];     // {pc, inst}, head first
  logic [31:0] m_stall, m_drop;
  int          m_reqs;
  logic [31:0] m_last_req;
  logic [31:0] m_pops[$];     // PCs consumed by decode

  task automatic model_reset();
    m_fetch_pc = RESET_PC;
    m_ot.delete();
    m_fifo.delete();
    m_stall = 0;
    m_drop  = 0;
    m_reqs  = 0;
    m_last_req = 32'hFFFF_FFFF;
  endtask

  function automatic bit exp_rv();
    int live = 0;
    foreach (m_ot[i]) if (!m_ot[i].stale) live++;
    return !rst && !redirect_valid && (m_ot.size() < MAXO) && (m_fifo.size() + live < DEPTH);
  endfunction

  // One clock cycle: sample just before the edge, update model and memory after it.
  task automatic tick();
    bit          rv_m, rf_m, resp_m, pop_m, dut_fire, dut_rack;
    logic [31:0] dut_pc, ins;
    ot_t         rec;
    @(negedge clk);
    rv_m     = exp_rv();
    rf_m     = rv_m && bus.Inst_Req_Ready;
    resp_m   = !rst && bus.Inst_Valid && (m_ot.size() != 0);
    ins      = bus.Instruction;
    pop_m    = !rst && !redirect_valid && bus.out_ready && (m_fifo.size() != 0);
    dut_fire = bus.Inst_Req_Valid && bus.Inst_Req_Ready;
    dut_pc   = bus.PC;
    dut_rack = bus.Inst_Valid && bus.Inst_Ready && (mem_q.size() != 0) && resp_en;
    @(posedge clk);
    #1;
    if (rst) mem_q.delete();
    else begin
      if (dut_rack) void'(mem_q.pop_front());
      if (dut_fire) mem_q.push_back(dut_pc);
    end
    if (rst) model_reset();
    else begin
      if (pop_m) m_pops.push_back(m_fifo.pop_front() >> 32);
      if (resp_m) begin
        rec = m_ot.pop_front();
        if (rec.stale || redirect_valid) m_drop++;
        else m_fifo.push_back({rec.addr, ins});
      end
      if (redirect_valid) begin
        m_fifo.delete();
        foreach (m_ot[i]) m_ot[i].stale = 1'b1;
        m_fetch_pc = redirect_pc;
      end else begin
        if (rf_m) begin
          m_ot.push_back('{addr: m_fetch_pc, stale: 1'b0});
          m_last_req = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 32'd4;
          m_reqs++;
        end
        if (rv_m && !bus.Inst_Req_Ready) m_stall++;
      end
    end
    drive_mem();
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc",        bus.PC, m_fetch_pc);
      check("req_valid", 32'(bus.Inst_Req_Valid), 32'(exp_rv()));
      check("inst_ready",32'(bus.Inst_Ready), 32'(rst || (m_ot.size() != 0)));
      check("out_valid", 32'(bus.out_valid), 32'(m_fifo.size() != 0));
      check("occupancy", 32'(occupancy), 32'(m_fifo.size()));
      if (m_fifo.size() != 0) begin
        check("out_pc",   bus.out_pc,   m_fifo[0][63:32]);
        check("out_inst", bus.out_inst, m_fifo[0][31:0]);
      end
      check("stall_cnt", perf_req_stall_cnt, m_stall);
      check("drop_cnt",  perf_drop_cnt,      m_drop);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.Inst_Req_Ready = 1'b1;
    bus.out_ready      = 1'b1;
    model_reset();
    drive_mem();
    tick();
    chk_en = 1'b1;
    tick();

    // T1: streaming fetch, first output one cycle after first response
    rst = 1'b0;
    m_pops.delete();
    tick();
    check("t1_valid_early", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_out_pc", bus.out_pc, 32'h0);
    check("t1_out_inst", bus.out_inst, inst_of(32'h0));
    repeat (6) tick();
    check("t1_pop0", m_pops[0], 32'h0);
    check("t1_pop1", m_pops[1], 32'h4);
    check("t1_pop2", m_pops[2], 32'h8);

    // T2: decode stalled, credit limits issue to DEPTH requests
    rst = 1'b1; tick();
    rst = 1'b0; bus.out_ready = 1'b0;
    repeat (10) tick();
    check("t2_occ", 32'(occupancy), 32'd4);
    check("t2_reqs", 32'(m_reqs), 32'd4);
    check("t2_rv_low", 32'(bus.Inst_Req_Valid), 32'd0);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;
    check("t2_pc", bus.PC, 32'h10);
    check("t2_rv_high", 32'(bus.Inst_Req_Valid), 32'd1);
    repeat (4) tick();
    check("t2_reqs2", 32'(m_reqs), 32'd5);
    check("t2_last_req", m_last_req, 32'h10);

    // T3: redirect with 0x8 and 0xC in flight
    rst = 1'b1; bus.out_ready = 1'b1; tick();
    rst = 1'b0;
    repeat (3) tick();
    resp_en = 1'b0; drive_mem();
    tick();
    check("t3_inflight", 32'(m_ot.size()), 32'd2);
    check("t3_ot0", m_ot[0].addr, 32'h8);
    check("t3_ot1", m_ot[1].addr, 32'hC);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; resp_en = 1'b1; drive_mem();
    m_pops.delete();
    repeat (8) tick();
    check("t3_drop", perf_drop_cnt, 32'd2);
    check("t3_pop0", m_pops[0], 32'h100);

    // T4: redirect in the same cycle as a response and a pop
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t4_pre_valid", 32'(bus.out_valid & bus.Inst_Valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    m_pops.delete();
    tick();
    redirect_valid = 1'b0;
    check("t4_occ", 32'(occupancy), 32'd0);
    check("t4_drop", perf_drop_cnt, 32'd1);
    check("t4_inflight", 32'(m_ot.size()), 32'd0);
    repeat (6) tick();
    check("t4_pop0", m_pops[0], 32'h200);

    // T5: request not accepted for 5 cycles; spurious response ignored
    rst = 1'b1; tick();
    rst = 1'b0; bus.Inst_Req_Ready = 1'b0; spurious = 1'b1; drive_mem();
    repeat (5) tick();
    check("t5_stall", perf_req_stall_cnt, 32'd5);
    check("t5_pc", bus.PC, 32'h0);
    check("t5_rv", 32'(bus.Inst_Req_Valid), 32'd1);
    check("t5_occ", 32'(occupancy), 32'd0);
    spurious = 1'b0; bus.Inst_Req_Ready = 1'b1; drive_mem();
    repeat (3) tick();

    // T6: reset with 3 entries buffered and 1 in flight
    rst = 1'b1; tick();
    rst = 1'b0; bus.out_ready = 1'b0; bus.Inst_Req_Ready = 1'b0;
    repeat (2) tick();
    bus.Inst_Req_Ready = 1'b1;
    repeat (4) tick();
    check("t6_occ_pre", 32'(occupancy), 32'd3);
    check("t6_inflight_pre", 32'(m_ot.size()), 32'd1);
    check("t6_stall_pre", perf_req_stall_cnt, 32'd2);
    rst = 1'b1; tick();
    check("t6_occ", 32'(occupancy), 32'd0);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_pc", bus.PC, RESET_PC);
    check("t6_stall", perf_req_stall_cnt, 32'd0);
    check("t6_drop", perf_drop_cnt, 32'd0);

    // T7: back-to-back redirects, last wins, fetch address wraps at 2^32
    rst = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'hFFFF_FFF8;
    m_pops.delete();
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    check("t7_drop", perf_drop_cnt, 32'd1);
    check("t7_pop0", m_pops[0], 32'hFFFF_FFF8);
    check("t7_pop1", m_pops[1], 32'hFFFF_FFFC);
    check("t7_pop2", m_pops[2], 32'h0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
